// File: rtl/demux_route_ctrl.sv
// Routes a valid/ready word stream to three demux destinations in turn, with a fixed word count per destination.
// Optional build macro DEMUX_ROUTE_CTRL_STALL_CNT_EN adds the saturating stall_cnt output.
module demux_route_ctrl #(
  parameter int LEN0  = 784,
  parameter int LEN1  = 128,
  parameter int LEN2  = 10,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       dst_ready,
  output logic [2:0]       dst_valid,
  output logic [1:0]       sel,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, R0, R1, R2, DONE} state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  state_t     first_st;
  state_t     after_st;
  logic       routing;
  logic [1:0] k;
  logic       last_word;
  logic       xfer;

  // Destinations with a zero length are skipped when choosing where to go next.
  always_comb begin
    first_st  = (LEN0 != 0) ? R0 : (LEN1 != 0) ? R1 : (LEN2 != 0) ? R2 : DONE;
    after_st  = DONE;
    routing   = 1'b0;
    k         = 2'd0;
    last_word = 1'b0;
    case (state_q)
      R0: begin
        routing   = 1'b1;
        k         = 2'd0;
        last_word = (cnt_q == CNT_W'(LEN0 - 1));
        after_st  = (LEN1 != 0) ? R1 : (LEN2 != 0) ? R2 : DONE;
      end
      R1: begin
        routing   = 1'b1;
        k         = 2'd1;
        last_word = (cnt_q == CNT_W'(LEN1 - 1));
        after_st  = (LEN2 != 0) ? R2 : DONE;
      end
      R2: begin
        routing   = 1'b1;
        k         = 2'd2;
        last_word = (cnt_q == CNT_W'(LEN2 - 1));
        after_st  = DONE;
      end
      default: ;
    endcase
  end

  assign in_ready  = routing & dst_ready[k];
  assign dst_valid = (routing && in_valid) ? (3'b001 << k) : 3'b000;
  assign xfer      = in_valid & in_ready;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      R0:      sel_of = 2'd0;
      R1:      sel_of = 2'd1;
      R2:      sel_of = 2'd2;
      default: sel_of = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        sel_q   <= 2'd3;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q <= first_st;
              sel_q   <= sel_of(first_st);
              busy_q  <= 1'b1;
              done_q  <= (first_st == DONE);
            end
          end
          R0, R1, R2: begin
            if (xfer) begin
              if (last_word) begin
                cnt_q   <= '0;
                state_q <= after_st;
                sel_q   <= sel_of(after_st);
                done_q  <= (after_st == DONE);
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            sel_q   <= 2'd3;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            sel_q   <= 2'd3;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel      = sel_q;
  assign word_cnt = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // Only an accepted start clears the count; abort and frame end leave it readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start && !abort) begin
      stall_q <= '0;
    end else if (routing && in_valid && !dst_ready[k] && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scoreboard bench for demux_route_ctrl: three instances (default, skipped destination, all-zero lengths).
module tb_demux_route_ctrl;

  localparam int CW = 10;

  typedef struct {
    logic [1:0] s;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic          start_s     [3];
  logic          abort_s     [3];
  logic          in_valid_s  [3];
  logic [2:0]    dst_ready_s [3];
  logic          in_ready_s  [3];
  logic [2:0]    dst_valid_s [3];
  logic [1:0]    sel_s       [3];
  logic [CW-1:0] wc_s        [3];
  logic          busy_s      [3];
  logic          done_s      [3];
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
  logic [15:0]   stall_s     [3];
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_route_ctrl #(.LEN0(784), .LEN1(128), .LEN2(10), .CNT_W(CW)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .dst_ready(dst_ready_s[0]),
    .dst_valid(dst_valid_s[0]), .sel(sel_s[0]), .word_cnt(wc_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_s[0])
`endif
  );

  demux_route_ctrl #(.LEN0(4), .LEN1(0), .LEN2(2), .CNT_W(CW)) u_skip (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .dst_ready(dst_ready_s[1]),
    .dst_valid(dst_valid_s[1]), .sel(sel_s[1]), .word_cnt(wc_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_s[1])
`endif
  );

  demux_route_ctrl #(.LEN0(0), .LEN1(0), .LEN2(0), .CNT_W(CW)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .dst_ready(dst_ready_s[2]),
    .dst_valid(dst_valid_s[2]), .sel(sel_s[2]), .word_cnt(wc_s[2]),
    .busy(busy_s[2]), .done(done_s[2])
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_s[2])
`endif
  );

  function automatic int len_of(input int k, input int d);
    case (k)
      0:       len_of = (d == 0) ? 784 : (d == 1) ? 128 : 10;
      1:       len_of = (d == 0) ? 4 : (d == 1) ? 0 : 2;
      default: len_of = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_busy"}, 32'(busy_s[k]), 32'd0);
    chk({tag, "_sel"}, 32'(sel_s[k]), 32'd3);
    chk({tag, "_wc"}, 32'(wc_s[k]), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready_s[k]), 32'd0);
    chk({tag, "_dv"}, 32'(dst_valid_s[k]), 32'd0);
    chk({tag, "_done"}, 32'(done_s[k]), 32'd0);
  endtask

  // One frame on instance k. Negative arguments disable the stall, abort,
  // mid-frame start, async reset and absolute done-cycle checks.
  task automatic run_frame(input int k, input int stall_at, input int stall_len,
                           input int abort_at, input int mstart_at, input int rst_at,
                           input bit gaps, input int want_cyc);
    exp_t       q[$];
    exp_t       e;
    int         total, xfers, stalled, last_x, done_cyc;
    bit         stall, ab, did_ms, xf;
    logic [2:0] exp_dv;
    total = len_of(k, 0) + len_of(k, 1) + len_of(k, 2);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < len_of(k, d); i++) begin
        e.s = 2'(d);
        e.c = i;
        q.push_back(e);
      end
    @(negedge clk);
    start_s[k] = 1'b1;
    in_valid_s[k] = 1'b1;
    dst_ready_s[k] = 3'b111;
    #1;
    chk("idle_rdy", 32'(in_ready_s[k]), 32'd0);
    chk("idle_dv", 32'(dst_valid_s[k]), 32'd0);
    xfers = 0; stalled = 0; last_x = 0; done_cyc = -1; did_ms = 1'b0;
    for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      stall = (xfers == stall_at) && (stalled < stall_len);
      if (stall) stalled++;
      ab = (xfers == abort_at);
      start_s[k] = (xfers == mstart_at) && !did_ms;
      if (start_s[k]) did_ms = 1'b1;
      abort_s[k] = ab;
      dst_ready_s[k] = stall ? 3'b000 : 3'b111;
      in_valid_s[k] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall) in_valid_s[k] = 1'b1;
      #1;
      if (q.size() > 0) begin
        e = q[0];
        exp_dv = in_valid_s[k] ? (3'b001 << e.s) : 3'b000;
        xf = in_valid_s[k] && dst_ready_s[k][e.s];
        chk("sel", 32'(sel_s[k]), 32'(e.s));
        chk("wc", 32'(wc_s[k]), 32'(e.c));
        chk("busy", 32'(busy_s[k]), 32'd1);
        chk("rdy", 32'(in_ready_s[k]), 32'(dst_ready_s[k][e.s]));
        chk("dv", 32'(dst_valid_s[k]), 32'(exp_dv));
        chk("done_early", 32'(done_s[k]), 32'd0);
        if (rst_at >= 0 && xfers == rst_at) begin
          #1 rst_n = 1'b0;
          #1;
          chk_idle(k, "arst");
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
          chk("arst_stall", 32'(stall_s[k]), 32'd0);
`endif
          @(negedge clk);
          rst_n = 1'b1;
          in_valid_s[k] = 1'b0; start_s[k] = 1'b0; abort_s[k] = 1'b0; dst_ready_s[k] = 3'b000;
          return;
        end
        if (ab) begin
          @(negedge clk);
          abort_s[k] = 1'b0;
          start_s[k] = 1'b0;
          in_valid_s[k] = 1'b1;
          #1;
          chk_idle(k, "abort");
          repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_nodone", 32'(done_s[k]), 32'd0);
            chk("abort_busy", 32'(busy_s[k]), 32'd0);
          end
          in_valid_s[k] = 1'b0; dst_ready_s[k] = 3'b000;
          return;
        end
        if (xf) begin
          void'(q.pop_front());
          xfers++;
          last_x = cyc;
        end
      end else begin
        chk("done", 32'(done_s[k]), 32'd1);
        chk("done_busy", 32'(busy_s[k]), 32'd1);
        chk("done_sel", 32'(sel_s[k]), 32'd3);
        chk("done_dv", 32'(dst_valid_s[k]), 32'd0);
        chk("done_rdy", 32'(in_ready_s[k]), 32'd0);
        done_cyc = cyc;
      end
    end
    in_valid_s[k] = 1'b0; start_s[k] = 1'b0; abort_s[k] = 1'b0; dst_ready_s[k] = 3'b000;
    if (done_cyc < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("xfers", 32'(xfers), 32'(total));
      chk("done_lat", 32'(done_cyc), (total == 0) ? 32'd1 : 32'(last_x + 1));
      if (want_cyc >= 0) chk("done_cyc", 32'(done_cyc), 32'(want_cyc));
      @(negedge clk);
      #1;
      chk_idle(k, "post");
`ifdef DEMUX_ROUTE_CTRL_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_s[k]), 32'(stalled));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; in_valid_s[i] = 1'b0; dst_ready_s[i] = 3'b000;
    end
    #12;
    for (int i = 0; i < 3; i++) chk_idle(i, "rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, -1, 0, -1, -1, -1, 1'b0, 923);
    run_frame(0, 5, 7, -1, 100, -1, 1'b0, 930);
    run_frame(0, -1, 0, 834, -1, -1, 1'b0, -1);
    run_frame(0, -1, 0, -1, -1, -1, 1'b0, 923);
    run_frame(1, -1, 0, -1, -1, -1, 1'b0, 7);
    run_frame(1, -1, 0, -1, -1, -1, 1'b1, -1);
    run_frame(2, -1, 0, -1, -1, -1, 1'b0, 1);

    @(negedge clk);
    start_s[1] = 1'b1; abort_s[1] = 1'b1; in_valid_s[1] = 1'b1; dst_ready_s[1] = 3'b111;
    @(negedge clk);
    start_s[1] = 1'b0; abort_s[1] = 1'b0;
    #1;
    chk_idle(1, "start_abort");
    in_valid_s[1] = 1'b0; dst_ready_s[1] = 3'b000;

    run_frame(0, -1, 0, -1, -1, 917, 1'b0, -1);
    run_frame(0, -1, 0, -1, -1, -1, 1'b0, 923);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
